// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - ALU with single-cycle logic/arith ops and iterative unsigned multiply/divide
// Multiply and divide share the hi_r/lo_r pair as their working registers and as the result.
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             dz
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic             dz_r;

  logic [WIDTH-1:0] quick_y;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic             last_iter;
  logic             b_is_zero;

  assign b_is_zero = (b == '0);
  assign last_iter = (cnt == CNT_W'(1));

  always_comb begin
    quick_y = '0;
    case (select)
      OP_AND:  quick_y = a & b;
      OP_OR:   quick_y = a | b;
      OP_ADD:  quick_y = a + b;
      OP_SUB:  quick_y = a + ~b + WIDTH'(1);
      OP_SLT:  quick_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  quick_y = a ^ b;
      default: quick_y = '0;
    endcase
  end

  // lo_r holds the multiplier, shifted out LSB-first while product bits shift in from the top.
  assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);

  // Remainder < divisor always holds, so the top bit of the difference is a clean borrow.
  assign div_shift = {hi_r, lo_r[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_r};
  assign div_ge    = ~div_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (select == OP_MULU)                    state_next = MUL;
          else if (select == OP_DIVU && !b_is_zero) state_next = DIV;
          else                                      state_next = DONE;
        end
      end
      MUL, DIV: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      b_r  <= '0;
      lo_r <= '0;
      hi_r <= '0;
      dz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_r  <= b;
            cnt  <= CNT_W'(WIDTH);
            dz_r <= 1'b0;
            hi_r <= '0;
            if (select == OP_MULU || select == OP_DIVU) begin
              lo_r <= a;
              if (select == OP_DIVU && b_is_zero) begin
                lo_r <= '1;
                hi_r <= a;
                dz_r <= 1'b1;
              end
            end else begin
              lo_r <= quick_y;
            end
          end
        end
        MUL: begin
          hi_r <= mul_sum[WIDTH:1];
          lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
          cnt  <= cnt - CNT_W'(1);
        end
        DIV: begin
          hi_r <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], div_ge};
          cnt  <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign y    = lo_r;
  assign hi   = hi_r;
  assign dz   = dz_r;
  assign zero = (lo_r == '0);

endmodule
